// File: rtl/bus_busy_handshake_if.sv
// -----------------------------------------------------------------------------
// bus_busy_handshake_if
// Groups the signals of bus_busy_handshake that are not clock or reset.
//   bus side  : pulsed bus_we_i / bus_we_ram_i / bus_address_i / bus_data_i in,
//               bus_data_o and module_busy_o back to the bus_cdc destination.
//   peripheral: per_req_o / per_we_o / per_addr_o / per_wdata_o / per_be_o out,
//               per_ack_i / per_rdata_i in.
//   status    : sticky timeout_o / overrun_o, cleared by flags_clr_i.
// Signal suffixes are seen from the adapter ("slave") side.
// -----------------------------------------------------------------------------
interface bus_busy_handshake_if #(
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned DataWidth    = 32
) ();
    logic                    bus_we_i;
    logic [3:0]              bus_we_ram_i;
    logic [AddressWidth-1:0] bus_address_i;
    logic [DataWidth-1:0]    bus_data_i;
    logic [DataWidth-1:0]    bus_data_o;
    logic                    module_busy_o;

    logic                    per_req_o;
    logic                    per_we_o;
    logic [AddressWidth-1:0] per_addr_o;
    logic [DataWidth-1:0]    per_wdata_o;
    logic [3:0]              per_be_o;
    logic                    per_ack_i;
    logic [DataWidth-1:0]    per_rdata_i;

    logic                    timeout_o;
    logic                    overrun_o;
    logic                    flags_clr_i;

    // Adapter side.
    modport slave (
        input  bus_we_i, bus_we_ram_i, bus_address_i, bus_data_i,
        input  per_ack_i, per_rdata_i, flags_clr_i,
        output bus_data_o, module_busy_o,
        output per_req_o, per_we_o, per_addr_o, per_wdata_o, per_be_o,
        output timeout_o, overrun_o
    );

    // Bus master plus peripheral, i.e. everything around the adapter.
    modport master (
        output bus_we_i, bus_we_ram_i, bus_address_i, bus_data_i,
        output per_ack_i, per_rdata_i, flags_clr_i,
        input  bus_data_o, module_busy_o,
        input  per_req_o, per_we_o, per_addr_o, per_wdata_o, per_be_o,
        input  timeout_o, overrun_o
    );
endinterface

// File: rtl/bus_busy_handshake.sv
// -----------------------------------------------------------------------------
// bus_busy_handshake
// Module-side adapter in a synchronized bus_cdc destination domain. A single-
// cycle bus pulse that hits [BaseAddress, EndAddress] starts a level req/ack
// handshake to a slow peripheral. module_busy_o stays high until the access
// completes (ack or timeout), and bus_data_o holds the read result after the
// busy falling edge so bus_cdc can sample it.
// Ports:
//   clk_i      destination-domain clock
//   reset_n_i  asynchronous active-low reset
//   bus        bus_busy_handshake_if.slave (bus, peripheral and flag signals)
// -----------------------------------------------------------------------------
module bus_busy_handshake #(
    parameter int unsigned                AddressWidth  = 32,
    parameter int unsigned                DataWidth     = 32,
    parameter logic [AddressWidth-1:0]    BaseAddress   = 'h0000_9000,
    parameter logic [AddressWidth-1:0]    EndAddress    = 'h0000_90FF,
    parameter int unsigned                TimeoutCycles = 255,
    parameter logic [DataWidth-1:0]       TimeoutData   = 'hDEAD_BEEF
) (
    input logic                clk_i,
    input logic                reset_n_i,
    bus_busy_handshake_if.slave bus
);

    // A zero TimeoutCycles disables expiry; keep at least one counter bit.
    localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0] TimeoutLast =
        CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam bit TimeoutEnabled = (TimeoutCycles > 0);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [AddressWidth-1:0] prev_addr_q, prev_addr_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    we_q, we_d;
    logic [DataWidth-1:0]    rdata_q, rdata_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;

    logic hit;
    logic is_write;
    logic expire;
    logic done;
    logic busy;

    // -------------------------------------------------------------------------
    // Request detect. The address is zero between pulses, so comparing against
    // last cycle's address turns a pulse into exactly one hit.
    // -------------------------------------------------------------------------
    always_comb begin
        hit      = (bus.bus_address_i >= BaseAddress) &&
                   (bus.bus_address_i <= EndAddress)  &&
                   (bus.bus_address_i != prev_addr_q);
        is_write = bus.bus_we_i | (|bus.bus_we_ram_i);
        expire   = TimeoutEnabled && (cnt_q == TimeoutLast);
        // Ack wins over a coincident expiry.
        done     = (state_q == REQ) && (bus.per_ack_i || expire);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before this edge, independent of process ordering.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (hit)  state_d = REQ;
            REQ:  if (done) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Busy and req are decoded straight from the state flop so a
    // reset drops them asynchronously.
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q == REQ);
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        prev_addr_d = bus.bus_address_i;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;

        if (state_q == IDLE) begin
            // Counter sits at zero so the first REQ cycle sees count 0.
            cnt_d = '0;
            if (hit) begin
                addr_d  = bus.bus_address_i - BaseAddress;
                wdata_d = bus.bus_data_i;
                we_d    = is_write;
                be_d    = (|bus.bus_we_ram_i) ? bus.bus_we_ram_i : 4'hF;
                rdata_d = '0;
            end
        end else begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CntWidth'(1);
            end
            if (done) begin
                if (we_q) begin
                    rdata_d = '0;
                end else if (bus.per_ack_i) begin
                    rdata_d = bus.per_rdata_i;
                end else begin
                    rdata_d = TimeoutData;
                end
            end
        end

        // Sticky flags: a clear is applied first so a same-cycle set wins.
        if (bus.flags_clr_i) begin
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (done && !bus.per_ack_i) begin
            timeout_d = 1'b1;
        end
        if ((state_q == REQ) && hit) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_addr_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_addr_q <= prev_addr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.module_busy_o = busy;
    assign bus.per_req_o     = busy;
    assign bus.per_we_o      = we_q;
    assign bus.per_addr_o    = addr_q;
    assign bus.per_wdata_o   = wdata_q;
    assign bus.per_be_o      = be_q;
    assign bus.bus_data_o    = rdata_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.overrun_o     = overrun_q;

endmodule

// File: tb/tb_bus_busy_handshake.sv
// -----------------------------------------------------------------------------
// tb_bus_busy_handshake
// Directed stimulus for bus_busy_handshake (TimeoutCycles = 8). Each access
// pushes its expected read data and busy-high length into a scoreboard queue;
// a monitor pops and compares on every busy falling edge and checks that the
// read data holds for two cycles afterwards.
// -----------------------------------------------------------------------------
module tb_bus_busy_handshake;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    typedef struct {
        logic [31:0] data;
        int          busy_len;
        string       name;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    bus_busy_handshake_if #(.AddressWidth(AW), .DataWidth(DW)) bus_if ();

    bus_busy_handshake #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .BaseAddress  (32'h0000_9000),
        .EndAddress   (32'h0000_90FF),
        .TimeoutCycles(TO),
        .TimeoutData  (32'hDEAD_BEEF)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus_if.slave)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: compares on each busy falling edge.
    initial begin : monitor
        logic        busy_prev;
        int          len;
        int          hold_left;
        logic [31:0] hold_val;
        exp_t        e;
        busy_prev = 1'b0;
        len       = 0;
        hold_left = 0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy_prev = 1'b0;
                len       = 0;
                hold_left = 0;
            end else begin
                if (hold_left > 0) begin
                    check("data_hold", bus_if.bus_data_o, hold_val);
                    hold_left--;
                end
                if (bus_if.module_busy_o) begin
                    len++;
                end else if (busy_prev) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_completion: got busy fall with data 0x%08h, expected none",
                                 bus_if.bus_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_rdata"}, bus_if.bus_data_o, e.data);
                        check({e.name, "_busy_len"}, 32'(len), 32'(e.busy_len));
                        hold_left = 2;
                        hold_val  = e.data;
                    end
                    len = 0;
                end
                busy_prev = bus_if.module_busy_o;
            end
        end
    end

    // One-cycle bus pulse; returns at the negedge after capture (first REQ cycle).
    task automatic pulse(input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] data);
        @(negedge clk);
        bus_if.bus_address_i = addr;
        bus_if.bus_we_i      = we;
        bus_if.bus_we_ram_i  = be;
        bus_if.bus_data_i    = data;
        @(negedge clk);
        bus_if.bus_address_i = '0;
        bus_if.bus_we_i      = 1'b0;
        bus_if.bus_we_ram_i  = '0;
        bus_if.bus_data_i    = '0;
    endtask

    // Single-cycle ack after n further negedges.
    task automatic ack_after(input int n, input logic [31:0] rdata);
        repeat (n) @(negedge clk);
        bus_if.per_ack_i   = 1'b1;
        bus_if.per_rdata_i = rdata;
        @(negedge clk);
        bus_if.per_ack_i   = 1'b0;
        bus_if.per_rdata_i = '0;
    endtask

    // Bounded wait for busy low, then leave room for the data-hold checks.
    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (bus_if.module_busy_o && i < 50) begin
            @(negedge clk);
            i++;
        end
        check({name, "_busy_bound"}, 32'(bus_if.module_busy_o), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        bus_if.flags_clr_i = 1'b1;
        @(negedge clk);
        bus_if.flags_clr_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus_if.bus_we_i      = 1'b0;
        bus_if.bus_we_ram_i  = '0;
        bus_if.bus_address_i = '0;
        bus_if.bus_data_i    = '0;
        bus_if.per_ack_i     = 1'b0;
        bus_if.per_rdata_i   = '0;
        bus_if.flags_clr_i   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy",    32'(bus_if.module_busy_o), 32'd0);
        check("rst_req",     32'(bus_if.per_req_o),     32'd0);
        check("rst_data",    bus_if.bus_data_o,         32'd0);
        check("rst_addr",    bus_if.per_addr_o,         32'd0);
        check("rst_flags",   32'({bus_if.timeout_o, bus_if.overrun_o}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read 0x9010, ack 3 cycles after req: busy 4 cycles.
        pulse(32'h9010, 1'b0, 4'h0, 32'h0);
        exp_q.push_back('{32'h1234_5678, 4, "read1"});
        check("read1_req",  32'(bus_if.per_req_o), 32'd1);
        check("read1_addr", bus_if.per_addr_o,     32'h10);
        check("read1_we",   32'(bus_if.per_we_o),  32'd0);
        check("read1_be",   32'(bus_if.per_be_o),  32'hF);
        ack_after(3, 32'h1234_5678);
        wait_idle("read1");

        // Write via byte enables; immediate ack -> minimum busy of one cycle.
        pulse(32'h9004, 1'b0, 4'b0011, 32'hA5A5_A5A5);
        exp_q.push_back('{32'h0, 1, "write1"});
        check("write1_clr_on_capture", bus_if.bus_data_o, 32'h0);
        check("write1_we",    32'(bus_if.per_we_o), 32'd1);
        check("write1_be",    32'(bus_if.per_be_o), 32'b0011);
        check("write1_wdata", bus_if.per_wdata_o,   32'hA5A5_A5A5);
        check("write1_addr",  bus_if.per_addr_o,    32'h4);
        ack_after(0, 32'hFFFF_FFFF);
        wait_idle("write1");

        // Read with no ack: 8 cycles of req, then timeout data.
        pulse(32'h9030, 1'b0, 4'h0, 32'h0);
        exp_q.push_back('{32'hDEAD_BEEF, 8, "timeout"});
        wait_idle("timeout");
        check("timeout_req_low", 32'(bus_if.per_req_o), 32'd0);
        check("timeout_flag",    32'(bus_if.timeout_o), 32'd1);
        repeat (3) @(negedge clk);
        check("timeout_sticky",  32'(bus_if.timeout_o), 32'd1);
        clear_flags();
        check("timeout_cleared", 32'(bus_if.timeout_o), 32'd0);

        // Second pulse while in REQ is dropped and flags overrun.
        pulse(32'h9040, 1'b0, 4'h0, 32'h0);
        exp_q.push_back('{32'h0BAD_F00D, 3, "overrun"});
        pulse(32'h9020, 1'b0, 4'h0, 32'h0);
        check("overrun_addr_kept", bus_if.per_addr_o,    32'h40);
        check("overrun_flag",      32'(bus_if.overrun_o), 32'd1);
        ack_after(0, 32'h0BAD_F00D);
        wait_idle("overrun");
        clear_flags();
        check("overrun_cleared", 32'(bus_if.overrun_o), 32'd0);

        // Ack in the same cycle as a new hit: completes, hit dropped.
        pulse(32'h9050, 1'b0, 4'h0, 32'h0);
        exp_q.push_back('{32'h5555_AAAA, 2, "ack_hit"});
        @(negedge clk);
        bus_if.bus_address_i = 32'h9060;
        bus_if.per_ack_i     = 1'b1;
        bus_if.per_rdata_i   = 32'h5555_AAAA;
        @(negedge clk);
        bus_if.bus_address_i = '0;
        bus_if.per_ack_i     = 1'b0;
        bus_if.per_rdata_i   = '0;
        check("ack_hit_busy",    32'(bus_if.module_busy_o), 32'd0);
        check("ack_hit_addr",    bus_if.per_addr_o,         32'h50);
        check("ack_hit_overrun", 32'(bus_if.overrun_o),     32'd1);
        wait_idle("ack_hit");
        clear_flags();

        // Out-of-range pulses just below and above the window.
        pulse(32'h8FFF, 1'b0, 4'h0, 32'h0);
        check("below_busy", 32'(bus_if.module_busy_o), 32'd0);
        pulse(32'h9100, 1'b1, 4'h0, 32'h0);
        check("above_busy", 32'(bus_if.module_busy_o), 32'd0);
        @(negedge clk);
        check("above_req",  32'(bus_if.per_req_o),     32'd0);
        check("range_overrun", 32'(bus_if.overrun_o),  32'd0);

        // Ack coinciding with the last timeout count: normal completion.
        pulse(32'h9070, 1'b0, 4'h0, 32'h0);
        exp_q.push_back('{32'h7777_0007, 8, "ack_expiry"});
        ack_after(7, 32'h7777_0007);
        wait_idle("ack_expiry");
        check("ack_expiry_no_timeout", 32'(bus_if.timeout_o), 32'd0);

        // Reset in the middle of REQ.
        pulse(32'h9080, 1'b0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(bus_if.module_busy_o), 32'd0);
        check("rst_mid_req",  32'(bus_if.per_req_o),     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_mid_flags", 32'({bus_if.timeout_o, bus_if.overrun_o}), 32'd0);
        repeat (2) @(negedge clk);

        // New read at the base address after reset.
        pulse(32'h9000, 1'b0, 4'h0, 32'h0);
        exp_q.push_back('{32'hCAFE_F00D, 2, "post_rst"});
        check("post_rst_addr", bus_if.per_addr_o, 32'h0);
        ack_after(1, 32'hCAFE_F00D);
        wait_idle("post_rst");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_busy_handshake.md
Name: bus_busy_handshake

Overview:
- Module-side adapter in a synchronized (non-bypass) bus_cdc destination domain.
- Takes the single-cycle pulsed bus from a bus_cdc output and drives a slow peripheral through a req/ack handshake.
- Holds module_busy high until the access completes; bus_cdc returns read data to the CPU on the busy falling edge.
- Has a timeout that guarantees busy always falls, so the CPU halt cannot hang.

Parameters:
- AddressWidth, 32, bus address width.
- DataWidth, 32, bus data width.
- BaseAddress, 32'h0000_9000, first decoded address. Must be nonzero.
- EndAddress, 32'h0000_90FF, last decoded address (inclusive).
- TimeoutCycles, 255, maximum REQ cycles without ack. 0 disables the timeout.
- TimeoutData, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk_i  in  1  destination-domain clock (cdc_clks_i entry).
- reset_n_i  in  1  asynchronous active-low reset.
- bus_we_i  in  1  pulsed we_o from bus_cdc.
- bus_we_ram_i  in  4  pulsed we_ram_o byte enables.
- bus_address_i  in  AddressWidth  pulsed address_o (0 between pulses).
- bus_data_i  in  DataWidth  pulsed write data.
- bus_data_o  out  DataWidth  read data to bus_cdc data_i.
- module_busy_o  out  1  to bus_cdc module_busy_i (module_busy_en_mask bit set).
- per_req_o  out  1  peripheral request, level, held until ack or timeout.
- per_we_o  out  1  peripheral write strobe qualifier.
- per_addr_o  out  AddressWidth  offset address: bus_address minus BaseAddress.
- per_wdata_o  out  DataWidth  captured write data.
- per_be_o  out  4  byte enables.
- per_ack_i  in  1  single-cycle completion from peripheral.
- per_rdata_i  in  DataWidth  read data, valid with per_ack_i.
- timeout_o  out  1  sticky: at least one timeout occurred.
- overrun_o  out  1  sticky: a request arrived while busy.
- flags_clr_i  in  1  synchronous clear of timeout_o and overrun_o.

Behaviour:

Reset (async assert, sync release):
- State IDLE.
- All outputs 0.
- Previous-address register 0.

Request detect:
- hit = BaseAddress <= bus_address_i <= EndAddress, and bus_address_i differs from its value registered last cycle.
- Write = bus_we_i OR |bus_we_ram_i.

IDLE:
- On hit, capture address offset, data, per_we_o and per_be_o (bus_we_ram_i if nonzero, else 4'hF). Go to REQ.
- From the next cycle: module_busy_o=1 and per_req_o=1.
- Minimum busy high time is 1 cycle, even if the ack comes immediately.
- per_ack_i in IDLE is ignored.

REQ:
- Timeout counter starts at 0 on entry and increments each cycle.
- On per_ack_i=1:
  - per_req_o and module_busy_o deassert next cycle.
  - bus_data_o <= per_rdata_i for reads, 0 for writes.
  - Go to IDLE.
- On counter == TimeoutCycles-1 with no ack (TimeoutCycles>0):
  - Same exit as ack, but bus_data_o <= TimeoutData (reads) or 0 (writes).
  - timeout_o <= 1.
- Ack on the timeout cycle takes priority as a normal ack; timeout_o is not set.
- A hit while in REQ is dropped and sets overrun_o <= 1. The in-flight access is unaffected.

Data hold:
- bus_data_o holds its value from busy deassertion until the next capture.
- This covers bus_cdc sampling data one cycle after the busy falling edge.
- bus_data_o is cleared to 0 at the next capture.

Flags:
- flags_clr_i clears both sticky flags.
- A same-cycle set wins over the clear.

Reset mid-REQ:
- Immediate return to IDLE.
- per_req_o and module_busy_o drop asynchronously.
- No flags are set.

Widths:
- Timeout counter is $clog2(TimeoutCycles+1) bits and saturates.
- The offset subtraction is truncated to AddressWidth.

Test Plan:
- Read 0x9010, ack 3 cycles after req with rdata 0x1234_5678 -> busy high exactly 4 cycles; per_addr_o=0x10; bus_data_o=0x1234_5678 held at least 2 cycles after busy falls.
- Write 0x9004, data 0xA5A5_A5A5, we_ram=4'b0011 -> per_we_o=1, per_be_o=0011, per_wdata_o=0xA5A5_A5A5; after ack, bus_data_o=0.
- Read with no ack, TimeoutCycles=8 -> per_req_o high 8 cycles then drops; bus_data_o=0xDEAD_BEEF; timeout_o=1 until flags_clr_i.
- Second pulse at 0x9020 while in REQ -> ignored (per_addr_o unchanged); overrun_o=1. Ack on the same cycle as a new hit -> access completes normally; the hit is dropped and sets overrun_o.
- Address 0x8FFF and 0x9100 pulses -> no req, busy stays 0. Same-cycle ack and expiry at count 7 -> normal completion; timeout_o stays 0.
- reset_n_i low during REQ -> per_req_o and busy drop immediately; after release, a new read at 0x9000 completes normally.
